// File: rtl/mux_rr_arb_pkg.sv
// Shared constants and helpers for the round-robin arbitrated mux.
package mux_rr_arb_pkg;

  // Arbitration mode encodings
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  localparam int DEF_DATA_WIDTH = 16;

  // Channel index width; never narrower than one bit
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_rr_arb_rr_grant.sv
// Combinational grant: rotating search starting at ptr (RR), or from 0 (fixed).
module rr_grant
  import mux_rr_arb_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int SEL_WIDTH = sel_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0]    req,
  input  logic [SEL_WIDTH-1:0] ptr,
  input  logic                 mode,
  output logic [NUM_CH-1:0]    gnt,
  output logic [SEL_WIDTH-1:0] idx
);

  int   start;
  int   c;
  logic found;

  // First requester at or after the start point, wrapping modulo NUM_CH
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    start = mode ? int'(ptr) : 0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = start + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = SEL_WIDTH'(c);
      end
    end
  end

endmodule

// File: rtl/mux_rr_arb.sv
// N-channel arbitrated mux with one registered output stage (valid/ready).
module mux_rr_arb
  import mux_rr_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_CH     = 4,
  parameter int RR_MODE    = MODE_RR,
  localparam int SEL_WIDTH = sel_w(NUM_CH)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NUM_CH-1:0]            valid_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
  output logic [NUM_CH-1:0]            ready_o,
  output logic                         valid_o,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic [SEL_WIDTH-1:0]         sel_o,
  input  logic                         ready_i
);

  localparam logic IS_RR = (RR_MODE == MODE_RR);

  logic [NUM_CH-1:0][DATA_WIDTH-1:0] ch_data;
  logic [NUM_CH-1:0]                 gnt;
  logic [SEL_WIDTH-1:0]              gnt_idx;
  logic                              can_acc;
  logic                              in_xfer;

  logic                  vld_d,  vld_q;
  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic [SEL_WIDTH-1:0]  sel_d,  sel_q;
  logic [SEL_WIDTH-1:0]  ptr_d,  ptr_q;

  // Flat bus viewed as per-channel words; channel k sits at k*DATA_WIDTH
  assign ch_data = data_i;

  rr_grant #(
    .NUM_CH    (NUM_CH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_grant (
    .req  (valid_i),
    .ptr  (ptr_q),
    .mode (IS_RR),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  // Handshake and next-state: load on input transfer, drain on output transfer
  always_comb begin
    can_acc = !vld_q || ready_i;
    ready_o = can_acc ? gnt : '0;
    in_xfer = |(valid_i & ready_o);
    vld_d   = vld_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (in_xfer) begin
      vld_d  = 1'b1;
      data_d = ch_data[gnt_idx];
      sel_d  = gnt_idx;
      if (IS_RR)
        ptr_d = (gnt_idx == SEL_WIDTH'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (vld_q && ready_i) begin
      vld_d = 1'b0;
    end
  end

  // State registers; reset drops any held beat and rewinds the pointer
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      sel_q  <= '0;
      ptr_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      sel_q  <= sel_d;
      ptr_q  <= ptr_d;
    end
  end

  assign valid_o = vld_q;
  assign data_o  = data_q;
  assign sel_o   = sel_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed bench for mux_rr_arb: RR instance with a beat scoreboard, plus a fixed-priority instance.
module tb_mux_rr_arb;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  s;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [3:0]  valid_i;
  logic [63:0] data_i;
  logic        ready_i;

  logic [3:0]  ready_o,  fp_ready_o;
  logic        valid_o,  fp_valid_o;
  logic [15:0] data_o,   fp_data_o;
  logic [1:0]  sel_o,    fp_sel_o;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mux_rr_arb #(.DATA_WIDTH(16), .NUM_CH(4), .RR_MODE(1)) u_dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .sel_o(sel_o),
    .ready_i(ready_i)
  );

  mux_rr_arb #(.DATA_WIDTH(16), .NUM_CH(4), .RR_MODE(0)) u_fp (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i),
    .ready_o(fp_ready_o), .valid_o(fp_valid_o), .data_o(fp_data_o), .sel_o(fp_sel_o),
    .ready_i(ready_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic [1:0] s);
    exp_t e;
    e.d = d;
    e.s = s;
    sb.push_back(e);
  endtask

  // Called once inputs for the coming edge are set: a beat leaving now is scored
  task automatic pop_check();
    exp_t e;
    if (valid_o && ready_i) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_data", 32'(data_o), 32'(e.d));
        chk("sb_sel",  32'(sel_o),  32'(e.s));
      end
    end
  endtask

  initial begin
    data_i  = {16'hA000, 16'h0A00, 16'h00A0, 16'h000A};
    reset_i = 1'b1;
    valid_i = 4'b0000;
    ready_i = 1'b1;

    // Reset and idle
    tick(); tick();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data",  32'(data_o),  32'h0);
    chk("rst_sel",   32'(sel_o),   32'd0);
    chk("rst_ready", 32'(ready_o), 32'h0);
    chk("rst_fp_valid", 32'(fp_valid_o), 32'd0);
    reset_i = 1'b0;
    tick();
    chk("idle_valid", 32'(valid_o), 32'd0);
    chk("idle_ready", 32'(ready_o), 32'h0);

    // Single channel 2
    valid_i = 4'b0100;
    #1;
    chk("single_ready", 32'(ready_o), 32'b0100);
    push(16'h0A00, 2'd2);
    tick();
    valid_i = 4'b0000;
    #1;
    chk("single_valid", 32'(valid_o), 32'd1);
    pop_check();
    tick();
    chk("single_drain", 32'(valid_o), 32'd0);

    // Round-robin fairness from a fresh pointer
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    valid_i = 4'b1111;
    push(16'h000A, 2'd0);
    push(16'h00A0, 2'd1);
    push(16'h0A00, 2'd2);
    push(16'hA000, 2'd3);
    push(16'h000A, 2'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_valid", 32'(valid_o), 32'd1);
      pop_check();
    end

    // Backpressure with 00A0/1 held
    push(16'h00A0, 2'd1);
    tick();
    ready_i = 1'b0;
    #1;
    chk("bp_ready0", 32'(ready_o), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 32'(valid_o), 32'd1);
      chk("bp_data",  32'(data_o),  32'h00A0);
      chk("bp_sel",   32'(sel_o),   32'd1);
      chk("bp_ready", 32'(ready_o), 32'h0);
    end
    ready_i = 1'b1;
    #1;
    pop_check();
    chk("bp_resume_ready", 32'(ready_o), 32'b0100);
    push(16'h0A00, 2'd2);
    tick();
    valid_i = 4'b0000;
    #1;
    pop_check();
    tick();
    chk("bp_drain", 32'(valid_o), 32'd0);

    // Fixed priority: channel 1 always beats channel 3
    valid_i = 4'b1010;
    #1;
    chk("fp_ready", 32'(fp_ready_o), 32'b0010);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fp_valid", 32'(fp_valid_o), 32'd1);
      chk("fp_data",  32'(fp_data_o),  32'h00A0);
      chk("fp_sel",   32'(fp_sel_o),   32'd1);
      chk("fp_ready_hold", 32'(fp_ready_o), 32'b0010);
    end

    // Reset while stalled
    valid_i = 4'b1111;
    ready_i = 1'b0;
    tick();
    chk("ms_stalled", 32'(valid_o), 32'd1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("ms_valid", 32'(valid_o), 32'd0);
    chk("ms_data",  32'(data_o),  32'h0);
    chk("ms_sel",   32'(sel_o),   32'd0);
    ready_i = 1'b1;
    push(16'h000A, 2'd0);
    tick();
    valid_i = 4'b0000;
    #1;
    chk("ms_first_valid", 32'(valid_o), 32'd1);
    pop_check();
    tick();

    chk("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_rr_arb.md
Name: mux_rr_arb

Overview:
- N-channel registered data multiplexer. Channel selection comes from a round-robin (or fixed-priority) arbiter instead of an external select.
- Each input channel has a valid/ready handshake. The output is a single registered stage with a valid/ready handshake.
- Successor to the 4-input combinational mux. It merges multiple producers (e.g. bus masters, operand sources) onto one downstream consumer in the processor datapath.

Parameters:
- DATA_WIDTH, 16, width of each data channel in bits.
- NUM_CH, 4, number of input channels; legal range 2..16.
- SEL_WIDTH, $clog2(NUM_CH), width of the channel index. Derived; never overridden.
- RR_MODE, 1, arbitration mode. 1 = round-robin. 0 = fixed priority, where channel 0 is highest.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- valid_i  input  NUM_CH  per-channel request; bit k belongs to channel k.
- data_i  input  NUM_CH*DATA_WIDTH  flattened channel data; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- ready_o  output  NUM_CH  per-channel accept; at most one bit is high in any cycle.
- valid_o  output  1  output register holds a beat.
- data_o  output  DATA_WIDTH  registered data of the held beat.
- sel_o  output  SEL_WIDTH  index of the channel that sourced data_o.
- ready_i  input  1  downstream accept.

Behaviour:
- Reset (reset_i high at a rising edge): valid_o=0, data_o=0, sel_o=0, round-robin pointer=0.
  - ready_o is combinational and reads 0 while valid_i is 0.
  - Reset mid-transfer discards the held beat. No input is accepted on the reset edge.
- Can-accept condition: can_acc = !valid_o || ready_i. The output register is either empty or draining this cycle.
- Grant (combinational):
  - RR_MODE=1: search channels ptr, ptr+1, …, NUM_CH-1, 0, …, ptr-1 (mod NUM_CH). The first k with valid_i[k] wins.
  - RR_MODE=0: the lowest-index k with valid_i[k] wins.
  - ready_o[k] = can_acc && grant[k]. All other ready_o bits are 0.
  - With no valid_i set, ready_o = 0.
- Input transfer on channel k = valid_i[k] && ready_o[k] at the clock edge. On the next cycle: valid_o=1, data_o=data_i[k], sel_o=k. Latency is 1 cycle.
- Output transfer = valid_o && ready_i.
  - If no input transfers in the same cycle, valid_o goes to 0 next cycle.
  - data_o/sel_o keep their last values; they are don't-care for the checker.
- Simultaneous output and input transfer: the register reloads with the new beat and valid_o stays 1. This gives full throughput of one beat per cycle.
- Stall: while valid_o && !ready_i, data_o, sel_o and valid_o hold stable and all ready_o = 0.
- Pointer (RR_MODE=1 only):
  - Updates only on an input transfer: ptr <= (k == NUM_CH-1) ? 0 : k+1. This wraps around for non-power-of-2 NUM_CH.
  - It is unchanged in all other cycles.
- Upstream rule: once valid_i[k] is asserted, data_i[k] holds until the transfer. The block does not check this rule.
- valid_i may drop without a transfer. The grant then re-evaluates in the same cycle.
- Fairness: with all channels continuously valid and ready_i=1, RR_MODE=1 grants 0,1,2,…,NUM_CH-1,0,… with no channel repeated within NUM_CH transfers.

Decomposition:
- Shared header/package holds:
  - the RR_MODE encodings (MODE_FIXED=0, MODE_RR=1);
  - the default DATA_WIDTH;
  - a SEL_WIDTH helper based on $clog2.
- One sub-module, rr_grant. It is purely combinational: inputs req, ptr and mode; outputs a one-hot grant and the encoded index.
- The top level holds the pointer, output register and handshake logic.

Test Plan:
- Reset and idle:
  - Stimulus: reset_i=1 for 2 cycles, then valid_i=0.
  - Required response: valid_o=0, data_o=0000, sel_o=0, ready_o=0000 throughout.
- Single channel:
  - Stimulus: data_i = {A000,0A00,00A0,000A}, valid_i=0100, ready_i=1.
  - Required response: ready_o=0100 that cycle. Next cycle valid_o=1, data_o=0A00, sel_o=2. The cycle after, valid_o=0.
- Round-robin fairness:
  - Stimulus: valid_i=1111 held, ready_i=1, same data_i as above.
  - Required response: the data_o sequence is 000A,00A0,0A00,A000,000A with sel_o 0,1,2,3,0, and valid_o stays 1 each cycle.
- Backpressure:
  - Stimulus: beat held with data_o=00A0; ready_i=0 for 3 cycles with valid_i=1111.
  - Required response: data_o/sel_o stable at 00A0/1 and ready_o=0000 for all 3 cycles. When ready_i returns to 1, the next beat is 0A00/2.
- Fixed priority:
  - Stimulus: RR_MODE=0, valid_i=1010 held, ready_i=1.
  - Required response: every beat is 00A0 with sel_o=1; channel 3 is never granted.
- Reset mid-stall:
  - Stimulus: valid_o=1 with ready_i=0, then reset_i asserted for 1 cycle.
  - Required response: next cycle valid_o=0, data_o=0000, pointer=0. With valid_i=1111 after reset, the first beat is 000A.
